// File: rtl/vga_console_writer_pkg.sv
// Shared types and constants for the text-console VRAM writer.
// Holds the FSM state enum, the control codes and the row-base address helper.
package vga_console_writer_pkg;

  typedef enum logic [1:0] {
    CLRSCR  = 2'd0,
    IDLE    = 2'd1,
    CLRLINE = 2'd2
  } state_e;

  localparam int unsigned ADDR_W = 11;

  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] FF = 8'h0C;
  localparam logic [7:0] CR = 8'h0D;

  // row*cols as a sum of shifted rows; cols is a constant, so this folds to adders.
  function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] row, input int unsigned cols);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++)
      if (cols[i]) acc = acc + (ADDR_W'(row) << i);
    return acc;
  endfunction

endpackage

// File: rtl/vga_console_writer_if.sv
// Producer handshake, VRAM write port and cursor/status outputs of the console writer.
interface vga_console_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, vram_waddr, vram_wdata, vram_we, cursor_col, cursor_row, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, vram_waddr, vram_wdata, vram_we, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/vga_console_writer.sv
// Character stream to text-mode VRAM writer: cursor tracking, control codes,
// and screen/line clears swept by a single address counter.
module vga_console_writer
  import vga_console_writer_pkg::*;
#(
  parameter int unsigned COLS  = 40,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_console_writer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [5:0]        COL_LAST  = 6'(COLS - 1);
  localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);

  state_e            state_q;
  logic [5:0]        col_q;
  logic [4:0]        row_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        wdata_q;
  logic              we_q;

  logic [4:0]        nxt_row_d;
  logic [ADDR_W-1:0] cur_addr_d, line_end_d, nl_base_d;

  always_comb begin
    nxt_row_d  = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
    cur_addr_d = row_base(row_q, COLS) + ADDR_W'(col_q);
    line_end_d = row_base(row_q, COLS) + ADDR_W'(COL_LAST);
    nl_base_d  = row_base(nxt_row_d, COLS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLRSCR;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        CLRSCR, CLRLINE: begin
          we_q    <= 1'b1;
          waddr_q <= cnt_q;
          wdata_q <= BLANK;
          cnt_q   <= cnt_q + 1'b1;
          // A line clear ends at its own row's last cell, a screen clear at the last cell.
          if ((state_q == CLRSCR && cnt_q == LAST_CELL) ||
              (state_q == CLRLINE && cnt_q == line_end_d))
            state_q <= IDLE;
        end
        IDLE: begin
          if (bus.in_valid) begin
            case (bus.in_data)
              CR: col_q <= '0;
              LF: begin
                col_q   <= '0;
                row_q   <= nxt_row_d;
                cnt_q   <= nl_base_d;
                state_q <= CLRLINE;
              end
              BS: begin
                if (col_q != '0) begin
                  col_q   <= col_q - 6'd1;
                  we_q    <= 1'b1;
                  waddr_q <= cur_addr_d - 1'b1;
                  wdata_q <= BLANK;
                end
              end
              FF: begin
                col_q   <= '0;
                row_q   <= '0;
                cnt_q   <= '0;
                state_q <= CLRSCR;
              end
              default: begin
                we_q    <= 1'b1;
                waddr_q <= cur_addr_d;
                wdata_q <= bus.in_data;
                if (col_q == COL_LAST) begin
                  col_q   <= '0;
                  row_q   <= nxt_row_d;
                  cnt_q   <= nl_base_d;
                  state_q <= CLRLINE;
                end else begin
                  col_q <= col_q + 6'd1;
                end
              end
            endcase
          end
        end
        default: state_q <= CLRSCR;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.vram_we    = we_q;
  assign bus.vram_waddr = waddr_q;
  assign bus.vram_wdata = wdata_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Bench for vga_console_writer: a per-cycle expected-output queue model plus directed
// literal checks for reset sweep, printing, wrap, row wrap, backspace, form feed and reset abort.
module tb_vga_console_writer;

  localparam int         COLS  = 40;
  localparam int         ROWS  = 30;
  localparam int         CELLS = COLS * ROWS;
  localparam logic [7:0] BL    = 8'h20;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_console_writer_if bus();

  vga_console_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // One entry per future output cycle: what the VRAM port must show on that cycle.
  typedef struct {
    logic        we;
    logic [10:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t q[$];
  int   mcol, mrow, busy_left;
  int   total = 0;
  int   bad   = 0;
  int   busy_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push(input logic we, input int a, input logic [7:0] d);
    ent_t e;
    e.we = we;
    e.a  = 11'(a);
    e.d  = d;
    q.push_back(e);
  endfunction

  function automatic void start_clear(input int first, input int n);
    for (int i = 0; i < n; i++) push(1'b1, first + i, BL);
    busy_left = n;
  endfunction

  function automatic void model_accept(input logic [7:0] c);
    case (c)
      8'h0D: mcol = 0;
      8'h0A: begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        push(1'b0, 0, 8'h00);
        start_clear(mrow * COLS, COLS);
      end
      8'h08: begin
        if (mcol > 0) begin
          mcol = mcol - 1;
          push(1'b1, mrow * COLS + mcol, BL);
        end
      end
      8'h0C: begin
        mcol = 0;
        mrow = 0;
        push(1'b0, 0, 8'h00);
        start_clear(0, CELLS);
      end
      default: begin
        push(1'b1, mrow * COLS + mcol, c);
        mcol = mcol + 1;
        if (mcol == COLS) begin
          mcol = 0;
          mrow = (mrow + 1) % ROWS;
          start_clear(mrow * COLS, COLS);
        end
      end
    endcase
  endfunction

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_we", bus.vram_we, 0);
      chk("rst_addr", bus.vram_waddr, 0);
      chk("rst_data", bus.vram_wdata, 0);
      chk("rst_busy", bus.busy, 1);
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_col", bus.cursor_col, 0);
      chk("rst_row", bus.cursor_row, 0);
      q.delete();
      mcol = 0;
      mrow = 0;
      busy_run = 0;
      push(1'b0, 0, 8'h00);
      start_clear(0, CELLS);
    end else begin
      logic busy_e;
      busy_e = (busy_left > 0);
      chk("busy", bus.busy, busy_e);
      chk("ready", bus.in_ready, !busy_e);
      chk("col", bus.cursor_col, mcol);
      chk("row", bus.cursor_row, mrow);
      if (q.size() > 0) begin
        ent_t e;
        e = q.pop_front();
        chk("we", bus.vram_we, e.we);
        if (e.we && bus.vram_we) begin
          chk("waddr", bus.vram_waddr, e.a);
          chk("wdata", bus.vram_wdata, e.d);
        end
      end else begin
        chk("we_idle", bus.vram_we, 0);
      end
      if (bus.busy) busy_run++;
      if (busy_left > 0) busy_left--;
      if (!busy_e && bus.in_valid) model_accept(bus.in_data);
    end
  end

  task automatic wait_ready(input int n);
    int k = 0;
    while (!bus.in_ready && k < n) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("ready_within_bound", bus.in_ready, 1);
  endtask

  task automatic send(input logic [7:0] c);
    wait_ready(3000);
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nw;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Power-up screen clear.
    wait_ready(2000);
    chk("init_busy_len", busy_run, 1200);
    chk("init_last_we", bus.vram_we, 1);
    chk("init_last_addr", bus.vram_waddr, 1199);
    chk("init_last_data", bus.vram_wdata, 8'h20);

    // Single printable.
    send(8'h41);
    chk("A_we", bus.vram_we, 1);
    chk("A_addr", bus.vram_waddr, 0);
    chk("A_data", bus.vram_wdata, 8'h41);
    chk("A_col", bus.cursor_col, 1);
    chk("A_row", bus.cursor_row, 0);

    // Full row of 40 printables wraps into a line clear of row 1.
    send(8'h0D);
    chk("CR_we", bus.vram_we, 0);
    for (int i = 0; i < COLS; i++) send(8'h42 + 8'(i % 26));
    chk("row40_addr", bus.vram_waddr, 39);
    chk("row40_data", bus.vram_wdata, 8'h42 + 8'(39 % 26));
    chk("row40_busy", bus.busy, 1);
    wait_ready(200);
    chk("wrap_clr_addr", bus.vram_waddr, 79);
    chk("wrap_clr_data", bus.vram_wdata, 8'h20);
    chk("wrap_col", bus.cursor_col, 0);
    chk("wrap_row", bus.cursor_row, 1);

    // Walk to row 29, then LF wraps to row 0; in_valid held high during clear is ignored.
    repeat (28) send(8'h0A);
    wait_ready(200);
    chk("row29", bus.cursor_row, 29);
    send(8'h0A);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h51;
    repeat (5) begin @(posedge clk); #1; end
    chk("lfwrap_ready_low", bus.in_ready, 0);
    chk("lfwrap_mid_addr", bus.vram_waddr, 4);
    wait_ready(200);
    bus.in_valid = 1'b0;
    chk("lfwrap_last_addr", bus.vram_waddr, 39);
    chk("lfwrap_col", bus.cursor_col, 0);
    chk("lfwrap_row", bus.cursor_row, 0);

    // Backspace at (5,2) and at column 0.
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h78);
    chk("pre_bs_col", bus.cursor_col, 5);
    send(8'h08);
    chk("bs_we", bus.vram_we, 1);
    chk("bs_addr", bus.vram_waddr, 84);
    chk("bs_data", bus.vram_wdata, 8'h20);
    chk("bs_col", bus.cursor_col, 4);
    chk("bs_row", bus.cursor_row, 2);
    send(8'h0D);
    send(8'h08);
    chk("bs0_we", bus.vram_we, 0);
    chk("bs0_col", bus.cursor_col, 0);

    // Form feed homes the cursor and sweeps the whole screen.
    send(8'h6D);
    send(8'h0C);
    chk("ff_col", bus.cursor_col, 0);
    chk("ff_row", bus.cursor_row, 0);
    chk("ff_busy", bus.busy, 1);
    chk("ff_no_write", bus.vram_we, 0);
    wait_ready(2000);
    chk("ff_last_addr", bus.vram_waddr, 1199);

    // Reset on the 10th write of a line clear.
    send(8'h0A);
    nw = 0;
    for (int k = 0; k < 100 && nw < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.vram_we) nw++;
    end
    chk("abort_nw", nw, 10);
    chk("abort_pre_addr", bus.vram_waddr, 49);
    reset = 1'b1;
    #1;
    chk("abort_we", bus.vram_we, 0);
    chk("abort_addr", bus.vram_waddr, 0);
    chk("abort_busy", bus.busy, 1);
    chk("abort_ready", bus.in_ready, 0);
    chk("abort_row", bus.cursor_row, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ready(2000);
    chk("abort_busy_len", busy_run, 1200);
    chk("abort_last_addr", bus.vram_waddr, 1199);

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_console_writer.md
VGA_CONSOLE_WRITER -- requirements
Module: vga_console_writer

Interface
REQ-001 SHALL have parameter COLS, default 40, text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, text rows per screen.
REQ-003 SHALL have parameter BLANK, default 8'h20, character code written when clearing cells.
REQ-004 SHALL have port clk  input  1  sole clock; also clocks the display VRAM write port.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_data  input  8  character code from the producer.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port vram_waddr  output  11  VRAM cell address, row*COLS+col.
REQ-010 SHALL have port vram_wdata  output  8  VRAM write data.
REQ-011 SHALL have port vram_we  output  1  VRAM write strobe, one write per asserted cycle.
REQ-012 SHALL have port cursor_col  output  6  current cursor column.
REQ-013 SHALL have port cursor_row  output  5  current cursor row.
REQ-014 SHALL have port busy  output  1  a screen or line clear is in progress.

Function
REQ-015 SHALL transfer a character only on a rising clk edge with in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready=1 only in state IDLE; in_valid SHALL be ignored in every other state.
REQ-017 SHALL implement states CLRSCR, IDLE and CLRLINE; busy=1 exactly in CLRSCR and CLRLINE.
REQ-018 SHALL register vram_waddr, vram_wdata and vram_we, so a write appears the cycle after acceptance (latency 1).
REQ-019 For a printable code (anything except 8'h08, 8'h0A, 8'h0C, 8'h0D), SHALL write the code at the cursor and then advance col by one.
REQ-020 On a col advance from COLS-1, SHALL set col=0 and perform the newline action (REQ-022).
REQ-021 For 8'h0D (CR), SHALL set col=0 with no write.
REQ-022 For 8'h0A (LF, newline), SHALL set col=0 and row=row+1; when row=ROWS-1 it SHALL wrap row to 0.
REQ-023 Every newline SHALL enter CLRLINE, writing BLANK to all COLS cells of the new row at addresses ascending from col 0, one per cycle, and then return to IDLE.
REQ-024 For 8'h08 (BS) with col>0, SHALL set col=col-1 and write BLANK there; with col=0 it SHALL do nothing.
REQ-025 For 8'h0C (FF), SHALL home the cursor to (0,0) and enter CLRSCR.
REQ-026 CLRSCR SHALL write BLANK to addresses 0..COLS*ROWS-1 in ascending order, one per cycle, then return to IDLE.
REQ-027 SHALL compute addresses without a multiplier (row*40 = (row<<5)+(row<<3) at defaults); the maximum address is 1199.
REQ-028 SHALL deassert vram_we on every cycle with no write.
REQ-029 cursor_col and cursor_row SHALL reflect the cursor after the last accepted character, and SHALL be stable while busy=1.

Reset
REQ-030 On reset SHALL force: cursor (0,0); vram_we=0; vram_waddr=0; vram_wdata=0; in_ready=0; state=CLRSCR; busy=1.
REQ-031 After reset deasserts, SHALL perform a full CLRSCR (COLS*ROWS writes) before first asserting in_ready.
REQ-032 A reset asserted mid-CLRLINE or mid-CLRSCR SHALL abort the clear and restart from REQ-030.

Structure
REQ-033 A shared package SHALL hold the state enum and the control-code constants BS, LF, FF and CR.
REQ-034 SHALL be a single module with no sub-modules; the clear sweep SHALL reuse one 11-bit address counter.

Verification
REQ-035 Reset release -> busy=1 for exactly 1200 cycles with vram_we=1, addresses 0..1199 and data 8'h20; in_ready then rises.
REQ-036 Send "A" (8'h41) with in_valid held high -> the next cycle writes addr 0, data 8'h41; cursor becomes (col 1, row 0).
REQ-037 Send 40 printable bytes from (0,0) -> the 40th is written at addr 39; then 40 BLANK writes at 40..79; cursor (0,1).
REQ-038 Cursor at row 29, send 8'h0A -> 40 BLANK writes at addr 0..39; cursor (0,0); in_ready=0 during the clear.
REQ-039 Cursor (5,2), send 8'h08 -> BLANK written at addr 84; cursor (4,2); at col 0, 8'h08 produces no write.
REQ-040 Assert reset during CLRLINE at its 10th write -> outputs go to reset values immediately, then a full 1200-cycle CLRSCR follows.
